if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
`default_nettype none
// ==========================================================================
// if_fetch : 6502-style instruction fetch and addressing-mode resolution
//            over a read-only memory port with fixed read latency.
// Revision : 1.0
// ==========================================================================
module if_fetch #(
   parameter int READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_start,
   input  logic [15:0] pc_next,
   input  logic [7:0]  x,
   input  logic [7:0]  y,
   output logic [15:0] mem_addr,
   output logic        mem_read_en,
   input  logic [7:0]  mem_data_in,
   output logic        if_ready,
   output logic [7:0]  opcode,
   output logic [3:0]  addr_mode,
   output logic [15:0] if_addr_out,
   output logic        immediate_flag,
   output logic [15:0] if_pc_next
);

   localparam logic [3:0] c_IMP  = 4'd0,  c_ACC  = 4'd1,  c_IMM  = 4'd2,  c_ZP   = 4'd3;
   localparam logic [3:0] c_ZPX  = 4'd4,  c_ZPY  = 4'd5,  c_ABS  = 4'd6,  c_ABSX = 4'd7;
   localparam logic [3:0] c_ABSY = 4'd8,  c_IND  = 4'd9,  c_INDX = 4'd10, c_INDY = 4'd11;
   localparam logic [3:0] c_REL  = 4'd12;

   localparam int WCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
   localparam logic [WCW-1:0] c_WAIT_LAST = WCW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_WAIT   = 3'd2,
      S_SAMPLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   function automatic logic [3:0] decode_mode(input logic [7:0] op);
      logic [3:0] m;
      m = c_IMP;
      case (op[1:0])
         2'b01: begin
            case (op[4:2])
               3'd0:    m = c_INDX;
               3'd1:    m = c_ZP;
               3'd2:    m = c_IMM;
               3'd3:    m = c_ABS;
               3'd4:    m = c_INDY;
               3'd5:    m = c_ZPX;
               3'd6:    m = c_ABSY;
               default: m = c_ABSX;
            endcase
         end
         2'b10: begin
            case (op[4:2])
               3'd0:    m = c_IMM;
               3'd1:    m = c_ZP;
               3'd2:    m = c_ACC;
               3'd3:    m = c_ABS;
               3'd5:    m = c_ZPX;
               3'd7:    m = c_ABSX;
               default: m = c_IMP;
            endcase
            // Register-transfer and X/Y-indexed store/load exceptions in this column
            if (op == 8'h8A || op == 8'hAA || op == 8'hCA || op == 8'hEA) m = c_IMP;
            else if (op == 8'h96 || op == 8'hB6)                          m = c_ZPY;
            else if (op == 8'hBE)                                         m = c_ABSY;
         end
         2'b00: begin
            case (op[4:2])
               3'd0: begin
                  if (op == 8'h20)                                   m = c_ABS;
                  else if (op == 8'h00 || op == 8'h40 || op == 8'h60) m = c_IMP;
                  else                                               m = c_IMM;
               end
               3'd1:    m = c_ZP;
               3'd3:    m = (op == 8'h6C) ? c_IND : c_ABS;
               3'd4:    m = c_REL;
               3'd5:    m = c_ZPX;
               3'd7:    m = c_ABSX;
               default: m = c_IMP;
            endcase
         end
         default: m = c_IMP;
      endcase
      return m;
   endfunction

   function automatic logic [2:0] mode_reads(input logic [3:0] m);
      case (m)
         c_IMP, c_ACC:                       return 3'd1;
         c_ABS, c_ABSX, c_ABSY:              return 3'd3;
         c_INDX, c_INDY:                     return 3'd4;
         c_IND:                              return 3'd5;
         default:                            return 3'd2;
      endcase
   endfunction

   function automatic logic [1:0] mode_len(input logic [3:0] m);
      case (m)
         c_IMP, c_ACC:                       return 2'd1;
         c_ABS, c_ABSX, c_ABSY, c_IND:       return 2'd3;
         default:                            return 2'd2;
      endcase
   endfunction

   state_t         state_q;
   logic [15:0]    pc_q, mem_addr_q, if_addr_q, if_pc_next_q;
   logic [7:0]     x_q, y_q, opcode_q;
   logic [7:0]     byte_q [5];
   logic [2:0]     idx_q;
   logic [WCW-1:0] wait_q;
   logic           mem_read_en_q, if_ready_q, imm_flag_q;
   logic [3:0]     addr_mode_q;

   logic [7:0]     w_byte [5];
   logic [3:0]     w_mode, mode_d;
   logic [2:0]     w_nreads, w_next_idx;
   logic [7:0]     w_zp_ptr, w_zp_ptr_inc, w_b1x, w_b1y;
   logic [1:0]     len_d;
   logic [15:0]    addr_d, ea_d, pc_next_d, w_abs;

   // Byte view that includes the byte arriving this cycle, so the next read
   // address can depend on it without an extra cycle.
   always_comb begin
      for (int i = 0; i < 5; i++) begin
         w_byte[i] = (idx_q == 3'(i)) ? mem_data_in : byte_q[i];
      end
      w_mode       = decode_mode(w_byte[0]);
      w_nreads     = mode_reads(w_mode);
      w_next_idx   = idx_q + 3'd1;
      w_zp_ptr     = w_byte[1] + ((w_mode == c_INDX) ? x_q : 8'h00);
      w_zp_ptr_inc = w_zp_ptr + 8'd1;
      addr_d       = pc_q + {13'd0, w_next_idx};
      case (w_mode)
         c_INDX, c_INDY: begin
            if (w_next_idx == 3'd2)      addr_d = {8'h00, w_zp_ptr};
            else if (w_next_idx == 3'd3) addr_d = {8'h00, w_zp_ptr_inc};
         end
         c_IND: begin
            // Pointer high byte stays in the same page (original NMOS behaviour)
            if (w_next_idx == 3'd3)      addr_d = {w_byte[2], w_byte[1]};
            else if (w_next_idx == 3'd4) addr_d = {w_byte[2], w_zp_ptr_inc};
         end
         default: ;
      endcase
   end

   always_comb begin
      mode_d    = decode_mode(byte_q[0]);
      len_d     = mode_len(mode_d);
      pc_next_d = pc_q + {14'd0, len_d};
      w_b1x     = byte_q[1] + x_q;
      w_b1y     = byte_q[1] + y_q;
      w_abs     = {byte_q[2], byte_q[1]};
      case (mode_d)
         c_IMM, c_ZP: ea_d = {8'h00, byte_q[1]};
         c_ZPX:       ea_d = {8'h00, w_b1x};
         c_ZPY:       ea_d = {8'h00, w_b1y};
         c_ABS:       ea_d = w_abs;
         c_ABSX:      ea_d = w_abs + {8'h00, x_q};
         c_ABSY:      ea_d = w_abs + {8'h00, y_q};
         c_INDX:      ea_d = {byte_q[3], byte_q[2]};
         c_INDY:      ea_d = {byte_q[3], byte_q[2]} + {8'h00, y_q};
         c_IND:       ea_d = {byte_q[4], byte_q[3]};
         c_REL:       ea_d = pc_next_d + {{8{byte_q[1][7]}}, byte_q[1]};
         default:     ea_d = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pc_q          <= 16'h0000;
         x_q           <= 8'h00;
         y_q           <= 8'h00;
         idx_q         <= 3'd0;
         wait_q        <= '0;
         mem_addr_q    <= 16'h0000;
         mem_read_en_q <= 1'b0;
         if_ready_q    <= 1'b0;
         opcode_q      <= 8'h00;
         addr_mode_q   <= 4'd0;
         if_addr_q     <= 16'h0000;
         imm_flag_q    <= 1'b0;
         if_pc_next_q  <= 16'h0000;
         for (int i = 0; i < 5; i++) byte_q[i] <= 8'h00;
      end else begin
         mem_read_en_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (if_start) begin
                  pc_q          <= pc_next;
                  x_q           <= x;
                  y_q           <= y;
                  idx_q         <= 3'd0;
                  mem_addr_q    <= pc_next;
                  mem_read_en_q <= 1'b1;
                  if_ready_q    <= 1'b0;
                  state_q       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wait_q  <= '0;
               state_q <= (READ_LATENCY > 1) ? S_WAIT : S_SAMPLE;
            end
            S_WAIT: begin
               if (wait_q == c_WAIT_LAST) state_q <= S_SAMPLE;
               else                       wait_q  <= wait_q + 1'b1;
            end
            S_SAMPLE: begin
               byte_q[idx_q] <= mem_data_in;
               if (w_next_idx == w_nreads) begin
                  state_q <= S_DONE;
               end else begin
                  idx_q         <= w_next_idx;
                  mem_addr_q    <= addr_d;
                  mem_read_en_q <= 1'b1;
                  state_q       <= S_ISSUE;
               end
            end
            S_DONE: begin
               opcode_q     <= byte_q[0];
               addr_mode_q  <= mode_d;
               if_addr_q    <= ea_d;
               imm_flag_q   <= (mode_d == c_IMM);
               if_pc_next_q <= pc_next_d;
               if_ready_q   <= 1'b1;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_addr       = mem_addr_q;
   assign mem_read_en    = mem_read_en_q;
   assign if_ready       = if_ready_q;
   assign opcode         = opcode_q;
   assign addr_mode      = addr_mode_q;
   assign if_addr_out    = if_addr_q;
   assign immediate_flag = imm_flag_q;
   assign if_pc_next     = if_pc_next_q;

endmodule
`default_nettype wire
